// File: rtl/ext_int_ctrl.sv
// External-interrupt controller: gates device requests with MSR[EE], drains the
// pipeline, takes the interrupt (SRR0/SRR1 save, vector redirect) and executes rfi.
module ext_int_ctrl #(
  parameter int          NUM_IRQ  = 4,
  parameter logic [31:0] VEC_ADDR = 32'h0000_0500,
  parameter logic [9:0]  SRR0_NUM = 10'd26,
  parameter logic [9:0]  SRR1_NUM = 10'd27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               EE,
  input  logic [0:31]        msr_rd,
  input  logic [0:31]        pc_cur,
  input  logic               safe,
  input  logic               rfi,
  input  logic               spr_wr,
  input  logic [9:0]         spr_addr,
  input  logic [0:31]        spr_wd,
  output logic               INT,
  output logic               msr_wr,
  output logic [0:31]        msr_wd,
  output logic               flush,
  output logic               npc_sel,
  output logic [0:31]        npc,
  output logic [0:31]        srr0,
  output logic [0:31]        srr1,
  output logic [2:0]         irq_id,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_TAKE  = 2'd2;
  localparam logic [1:0] S_RET   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [0:31]        srr0_q, srr0_d;
  logic [0:31]        srr1_q, srr1_d;
  logic [2:0]         id_r_q, id_r_d;
  logic [2:0]         irq_id_q, irq_id_d;
  logic [2:0]         win;
  logic               pending;

  assign pending = (|irq_q) & EE;

  // Lowest asserted index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    win = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_q[i]) win = 3'(i);
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_in;
    srr0_d   = srr0_q;
    srr1_d   = srr1_q;
    id_r_d   = id_r_q;
    irq_id_d = irq_id_q;

    if (spr_wr && (state_q == S_IDLE || state_q == S_DRAIN)) begin
      if (spr_addr == SRR0_NUM) srr0_d = spr_wd;
      if (spr_addr == SRR1_NUM) srr1_d = spr_wd;
    end

    case (state_q)
      S_IDLE: begin
        if (rfi) state_d = S_RET;
        else if (pending) begin
          state_d = S_DRAIN;
          id_r_d  = win;
        end
      end
      S_DRAIN: begin
        if (!pending) state_d = S_IDLE;
        else begin
          id_r_d = win;
          // The resume-point capture overrides a concurrent mtspr.
          if (safe) begin
            srr0_d  = pc_cur;
            srr1_d  = msr_rd;
            state_d = S_TAKE;
          end
        end
      end
      S_TAKE: begin
        irq_id_d = id_r_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      irq_q    <= '0;
      srr0_q   <= '0;
      srr1_q   <= '0;
      id_r_q   <= '0;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      srr0_q   <= srr0_d;
      srr1_q   <= srr1_d;
      id_r_q   <= id_r_d;
      irq_id_q <= irq_id_d;
    end
  end

  // Every output is a decode of registered state only.
  always_comb begin
    INT     = (state_q == S_TAKE);
    msr_wr  = (state_q == S_RET);
    msr_wd  = srr1_q;
    flush   = (state_q != S_IDLE);
    npc_sel = (state_q == S_TAKE) || (state_q == S_RET);
    npc     = '0;
    if (state_q == S_TAKE) npc = VEC_ADDR;
    else if (state_q == S_RET) npc = srr0_q;
    irq_ack = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      irq_ack[i] = (state_q == S_TAKE) && (id_r_q == 3'(i));
  end

  assign srr0   = srr0_q;
  assign srr1   = srr1_q;
  assign irq_id = irq_id_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl: take, priority, withdraw, EE gating, rfi, reset.
module tb_ext_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq_in;
  logic        EE;
  logic [0:31] msr_rd, pc_cur, spr_wd;
  logic        safe, rfi, spr_wr;
  logic [9:0]  spr_addr;
  logic        INT, msr_wr, flush, npc_sel;
  logic [0:31] msr_wd, npc, srr0, srr1;
  logic [2:0]  irq_id;
  logic [3:0]  irq_ack;

  int total = 0;
  int bad   = 0;

  ext_int_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .EE(EE), .msr_rd(msr_rd),
    .pc_cur(pc_cur), .safe(safe), .rfi(rfi), .spr_wr(spr_wr),
    .spr_addr(spr_addr), .spr_wd(spr_wd), .INT(INT), .msr_wr(msr_wr),
    .msr_wd(msr_wd), .flush(flush), .npc_sel(npc_sel), .npc(npc),
    .srr0(srr0), .srr1(srr1), .irq_id(irq_id), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1ns after it; also check INT/msr_wr exclusivity.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("int_wr_excl", 32'(INT & msr_wr), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; EE = 1'b1; msr_rd = '0; pc_cur = '0; safe = 1'b1;
    rfi = 1'b0; spr_wr = 1'b0; spr_addr = '0; spr_wd = '0;

    // 1. reset, then idle
    tick(); tick();
    chk("rst_int", 32'(INT), 0);       chk("rst_msr_wr", 32'(msr_wr), 0);
    chk("rst_flush", 32'(flush), 0);   chk("rst_npc_sel", 32'(npc_sel), 0);
    chk("rst_npc", npc, 0);            chk("rst_msr_wd", msr_wd, 0);
    chk("rst_srr0", srr0, 0);          chk("rst_srr1", srr1, 0);
    chk("rst_irq_id", 32'(irq_id), 0); chk("rst_ack", 32'(irq_ack), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_flush", 32'(flush), 0);
      chk("idle_int", 32'(INT), 0);
    end

    // 2. basic take
    msr_rd = 32'h0000_8000; pc_cur = 32'h0000_1234; irq_in = 4'b0100;
    tick();                                    // edge 0: irq_q set
    chk("take_c0_flush", 32'(flush), 0);
    tick();                                    // edge 1: DRAIN
    chk("take_c1_flush", 32'(flush), 1);       chk("take_c1_int", 32'(INT), 0);
    tick();                                    // edge 2: TAKE
    chk("take_int", 32'(INT), 1);              chk("take_npc_sel", 32'(npc_sel), 1);
    chk("take_npc", npc, 32'h0000_0500);       chk("take_ack", 32'(irq_ack), 32'b0100);
    chk("take_srr0", srr0, 32'h0000_1234);     chk("take_srr1", srr1, 32'h0000_8000);
    chk("take_flush", 32'(flush), 1);
    EE = 1'b0;
    tick();                                    // cycle 3: back to IDLE
    chk("take_c3_int", 32'(INT), 0);           chk("take_irq_id", 32'(irq_id), 2);
    chk("take_c3_ack", 32'(irq_ack), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("take_noretrig", 32'(INT), 0);
    end
    irq_in = '0; tick(); tick();

    // 3a. priority: lowest index wins
    EE = 1'b1; irq_in = 4'b1010;
    tick(); tick(); tick();
    chk("prio_int", 32'(INT), 1);              chk("prio_ack", 32'(irq_ack), 32'b0010);
    EE = 1'b0; irq_in = '0;
    tick();
    chk("prio_irq_id", 32'(irq_id), 1);
    tick();

    // 3b. withdraw while draining
    EE = 1'b1; safe = 1'b0; irq_in = 4'b0001;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("wd_flush", 32'(flush), 1);
      chk("wd_int", 32'(INT), 0);
      tick();
    end
    irq_in = '0;
    tick();                                    // irq_q clears
    chk("wd_int_late", 32'(INT), 0);
    tick();                                    // DRAIN sees !pending
    chk("wd_idle_flush", 32'(flush), 0);       chk("wd_idle_int", 32'(INT), 0);
    chk("wd_idle_ack", 32'(irq_ack), 0);
    tick();

    // 3c. higher-priority arrival during DRAIN replaces the winner
    irq_in = 4'b1000;
    tick(); tick(); tick();
    chk("repl_drain", 32'(flush), 1);
    irq_in = 4'b1001;
    tick(); tick();
    safe = 1'b1;
    tick();
    chk("repl_int", 32'(INT), 1);              chk("repl_ack", 32'(irq_ack), 32'b0001);
    EE = 1'b0; irq_in = '0;
    tick(); tick();

    // 4. EE gating
    irq_in = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ee_flush", 32'(flush), 0);
      chk("ee_int", 32'(INT), 0);
    end
    irq_in = '0; tick();

    // 5. mtspr then rfi
    EE = 1'b1;
    spr_wr = 1'b1; spr_addr = 10'd26; spr_wd = 32'h0000_2000;
    tick();
    chk("mtspr_srr0", srr0, 32'h0000_2000);
    spr_addr = 10'd27; spr_wd = 32'h0000_8001;
    tick();
    chk("mtspr_srr1", srr1, 32'h0000_8001);
    spr_addr = 10'd5; spr_wd = 32'hFFFF_FFFF;
    tick();
    chk("mtspr_other0", srr0, 32'h0000_2000);  chk("mtspr_other1", srr1, 32'h0000_8001);
    spr_wr = 1'b0; rfi = 1'b1;
    tick();
    rfi = 1'b0;
    chk("rfi_msr_wr", 32'(msr_wr), 1);         chk("rfi_msr_wd", msr_wd, 32'h0000_8001);
    chk("rfi_npc", npc, 32'h0000_2000);        chk("rfi_npc_sel", 32'(npc_sel), 1);
    chk("rfi_int", 32'(INT), 0);               chk("rfi_flush", 32'(flush), 1);
    tick();
    chk("rfi_done", 32'(msr_wr), 0);           chk("rfi_done_flush", 32'(flush), 0);

    // 5b. rfi beats a pending request; DRAIN follows at edge k+3
    EE = 1'b0; irq_in = 4'b0100;
    tick();
    EE = 1'b1; rfi = 1'b1;
    tick();                                    // edge k+1: RET
    rfi = 1'b0;
    chk("rp_ret", 32'(msr_wr), 1);             chk("rp_ret_int", 32'(INT), 0);
    tick();                                    // edge k+2: IDLE
    chk("rp_idle_flush", 32'(flush), 0);
    tick();                                    // edge k+3: DRAIN
    chk("rp_drain_flush", 32'(flush), 1);      chk("rp_drain_int", 32'(INT), 0);
    tick();
    chk("rp_take", 32'(INT), 1);
    EE = 1'b0; irq_in = '0;
    tick(); tick();

    // 6. reset mid-DRAIN with a persisting request
    EE = 1'b1; safe = 1'b0; irq_in = 4'b0010;
    tick(); tick();
    chk("rd_drain", 32'(flush), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rd_flush", 32'(flush), 0);            chk("rd_int", 32'(INT), 0);
    chk("rd_srr0", srr0, 0);                   chk("rd_srr1", srr1, 0);
    chk("rd_npc", npc, 0);
    tick();                                    // release edge: irq_q set
    chk("rd_c0_int", 32'(INT), 0);             chk("rd_c0_flush", 32'(flush), 0);
    tick();
    chk("rd_c1_flush", 32'(flush), 1);         chk("rd_c1_int", 32'(INT), 0);
    safe = 1'b1;
    tick();
    chk("rd_c2_int", 32'(INT), 1);             chk("rd_c2_ack", 32'(irq_ack), 32'b0010);
    EE = 1'b0; irq_in = '0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
